// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder slice processes WIDTH-bit operands LSB-first,
// one bit per clock, with the carry registered between bits.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] shs_q, shs_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             bit_s, bit_c;
  logic [WIDTH-1:0] shs_next;

  always_comb begin
    bit_s    = sha_q[0] ^ shb_q[0] ^ carry_q;
    bit_c    = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) | (shb_q[0] & carry_q);
    // Shift-and-or form keeps the WIDTH=1 case free of empty part-selects
    shs_next = (shs_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shs_d   = shs_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        shs_d   = shs_next;
        carry_d = bit_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = shs_next;
          cout_d  = bit_c;
          ovf_d   = carry_q ^ bit_c;
          cnt_d   = cnt_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      shs_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shs_q   <= shs_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
    sum   = sum_q;
    cout  = cout_q;
    ovf   = ovf_q;
  end

endmodule
